// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel-clock-enable divider, run/stop control
// and line/frame start strobes; all outputs registered and mutually aligned.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned PIX_DIV   = 1,
  parameter int unsigned CNT_W     = 12
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  output logic             pix_ce,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vga_blank,
  output logic [CNT_W-1:0] h_pos,
  output logic [CNT_W-1:0] v_pos,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  if (PIX_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV must be at least 1");
  end
  if ((64'(H_TOTAL) - 64'd1) >= (64'd1 << CNT_W)) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL-1 does not fit in CNT_W bits");
  end
  if ((64'(V_TOTAL) - 64'd1) >= (64'd1 << CNT_W)) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL-1 does not fit in CNT_W bits");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic             ce, visible, hs_act, vs_act;
  int unsigned      h_int, v_int;

  assign ce    = enable && (div_q == DIV_LAST);
  assign h_int = 32'(h_cnt_q);
  assign v_int = 32'(v_cnt_q);

  always_comb begin
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (ce) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
    visible = (h_int < H_VISIBLE) && (v_int < V_VISIBLE);
    hs_act  = (h_int >= HS_START) && (h_int < HS_END);
    vs_act  = (v_int >= VS_START) && (v_int < VS_END);
  end

  // Stopping (enable low) returns everything to the reset image on the next edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q       <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      h_pos       <= '0;
      v_pos       <= '0;
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vga_blank   <= 1'b1;
      vga_hsync   <= ~HS_POL;
      vga_vsync   <= ~VS_POL;
    end else if (!enable) begin
      div_q       <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      h_pos       <= '0;
      v_pos       <= '0;
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vga_blank   <= 1'b1;
      vga_hsync   <= ~HS_POL;
      vga_vsync   <= ~VS_POL;
    end else begin
      div_q       <= div_d;
      pix_ce      <= ce;
      line_start  <= ce && (h_cnt_q == '0);
      frame_start <= ce && (h_cnt_q == '0) && (v_cnt_q == '0);
      if (ce) begin
        h_cnt_q   <= h_cnt_d;
        v_cnt_q   <= v_cnt_d;
        h_pos     <= h_cnt_q;
        v_pos     <= v_cnt_q;
        vga_blank <= !visible;
        vga_hsync <= hs_act ? HS_POL : ~HS_POL;
        vga_vsync <= vs_act ? VS_POL : ~VS_POL;
      end
    end
  end

endmodule
